// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with a start/busy/done handshake, flush and divide-by-zero flag.
// Optional build macro MULDIV_DIV0_FAST_EN: a zero divisor skips the division iterations.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div0
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_a_neg;
    logic               r_b_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div0;
    logic               r_done;

    logic               w_x_neg;
    logic               w_y_neg;
    logic               w_b_zero;
    logic               w_skip;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_x_raw;

    assign w_x_neg  = i_op[0] & i_x[WIDTH-1];
    assign w_y_neg  = i_op[0] & i_y[WIDTH-1];
    assign w_b_zero = (r_b == '0);

`ifdef MULDIV_DIV0_FAST_EN
    assign w_skip = w_b_zero;
`else
    assign w_skip = 1'b0;
`endif

    assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Restoring step: dividend bits enter MSB-first from the untouched |x| register.
    assign w_shift = {r_acc_hi, r_a[r_cnt[CNT_W-2:0]]};
    assign w_trial = w_shift - {1'b0, r_b};

    assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_quo_fix  = (r_a_neg ^ r_b_neg) ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_a_neg ? -r_acc_hi : r_acc_hi;
    // Undoing the abs gives the raw dividend back (MIN maps onto itself).
    assign w_x_raw    = r_a_neg ? -r_a : r_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        // A start coinciding with the done pulse is dropped, not queued.
                        if (i_start && !r_done) begin
                            r_op     <= i_op;
                            r_a      <= w_x_neg ? -i_x : i_x;
                            r_b      <= w_y_neg ? -i_y : i_y;
                            r_a_neg  <= w_x_neg;
                            r_b_neg  <= w_y_neg;
                            r_cnt    <= i_op[1] ? CNT_W'(WIDTH - 1) : '0;
                            r_acc_hi <= '0;
                            r_acc_lo <= '0;
                            r_state  <= CALC;
                        end
                    end
                    CALC: begin
                        if (!r_op[1]) begin
                            {r_acc_hi, r_acc_lo} <= w_prod;
                            r_state <= FIN;
                        end else if (w_skip) begin
                            r_state <= FIN;
                        end else begin
                            if (!w_trial[WIDTH]) begin
                                r_acc_hi <= w_trial[WIDTH-1:0];
                                r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                r_acc_hi <= w_shift[WIDTH-1:0];
                                r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                            end
                            r_cnt <= r_cnt - CNT_W'(1);
                            if (r_cnt == '0) begin
                                r_state <= FIN;
                            end
                        end
                    end
                    FIN: begin
                        if (!r_op[1]) begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end else if (w_b_zero) begin
                            r_hi   <= w_x_raw;
                            r_lo   <= '1;
                            r_div0 <= 1'b1;
                        end else begin
                            r_hi   <= w_rem_fix;
                            r_lo   <= w_quo_fix;
                            r_div0 <= 1'b0;
                        end
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_div0 = r_div0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations vs. an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi   = 32'h0;
    logic [31:0] m_lo   = 32'h0;
    logic        m_div0 = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_flush(flush),
        .i_start(start),
        .i_op   (op),
        .i_x    (x),
        .i_y    (y),
        .o_busy (busy),
        .o_done (done),
        .o_hi   (hi),
        .o_lo   (lo),
        .o_div0 (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from integer arithmetic; updates the model's HI/LO/div0 state.
    task automatic model(input logic [1:0] mop, input logic [31:0] mx, input logic [31:0] my);
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        longint      sx;
        longint      sy;
        sx = longint'($signed(mx));
        sy = longint'($signed(my));
        case (mop)
            2'b00: begin
                p = {32'h0, mx} * {32'h0, my};
                {m_hi, m_lo} = p;
            end
            2'b01: begin
                p = sx * sy;
                {m_hi, m_lo} = p;
            end
            default: begin
                if (my == 32'h0) begin
                    m_lo   = 32'hFFFF_FFFF;
                    m_hi   = mx;
                    m_div0 = 1'b1;
                end else begin
                    if (mop == 2'b10) begin
                        m_lo = mx / my;
                        m_hi = mx % my;
                    end else begin
                        q    = sx / sy;
                        r    = sx % sy;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                    end
                    m_div0 = 1'b0;
                end
            end
        endcase
    endtask

    function automatic int latency(input logic [1:0] lop, input logic [31:0] ly);
        if (!lop[1]) return 2;
`ifdef MULDIV_DIV0_FAST_EN
        if (ly == 32'h0) return 2;
`endif
        return 33;
    endfunction

    // Inputs change #1 after a rising edge; outputs are sampled at the same point.
    task automatic run_op(input string tag, input logic [1:0] sop, input logic [31:0] sx,
                          input logic [31:0] sy, input bit start_on_done);
        int cyc;
        int lat;
        bit busy_ok;
        lat = latency(sop, sy);
        model(sop, sx, sy);
        op = sop; x = sx; y = sy; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); x = $urandom; y = $urandom;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy_while_calc"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
        check({tag, " div0"}, 64'(div0), 64'(m_div0));
        if (start_on_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        if (start_on_done) check({tag, " start_on_done_ignored"}, 64'(busy), 64'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check({tag, " no_activity"}, 64'(seen), 64'd0);
        check({tag, " hi_kept"}, 64'(hi), 64'(m_hi));
        check({tag, " lo_kept"}, 64'(lo), 64'(m_lo));
        check({tag, " div0_kept"}, 64'(div0), 64'(m_div0));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;

        rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00; x = 32'h0; y = 32'h0;
        #23;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset div0", 64'(div0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult_neg2x3", 2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op("divu_100_by0", 2'b10, 32'd100, 32'd0, 1'b0);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b1);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_m9_by0", 2'b11, 32'hFFFF_FFF7, 32'd0, 1'b1);
        run_op("mult_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rx  = $urandom;
            ry  = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(0, 31);
            run_op("random", rop, rx, ry, 1'($urandom));
        end

        // Flush mid-divide: prior result must survive and no done may appear.
        op = 2'b10; x = 32'd12345; y = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy_after", 64'(busy), 64'd0);
        expect_quiet("flush", 40);

        flush = 1'b1; start = 1'b1; op = 2'b00; x = 32'd5; y = 32'd6;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_start busy", 64'(busy), 64'd0);
        expect_quiet("flush_start", 5);

        // A second start while busy must neither alter the result nor queue another op.
        model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        op = 2'b00; x = 32'h1234_5678; y = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        op = 2'b11; x = 32'd99; y = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("busy_start done", 64'(done), 64'd1);
        check("busy_start hi", 64'(hi), 64'(m_hi));
        check("busy_start lo", 64'(lo), 64'(m_lo));
        expect_quiet("busy_start", 40);

        // Asynchronous reset in the middle of a divide clears everything immediately.
        op = 2'b11; x = 32'hF000_0001; y = 32'd77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        check("midreset div0", 64'(div0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'h0; m_lo = 32'h0; m_div0 = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset_divu", 2'b10, 32'hDEAD_BEEF, 32'd1000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
